// File: rtl/riscv_pkg.sv
// Shared instruction-cache types, default geometry and address-field width helpers.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      REFILL_REQ  = 2'd1,
      REFILL_DATA = 2'd2
   } icache_state_t;

   localparam int ICACHE_LINES          = 16;
   localparam int ICACHE_WORDS_PER_LINE = 4;

   function automatic int icache_off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int icache_idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag covers the word address (pc[31:2]) above offset and index.
   function automatic int icache_tag_w(input int lines, input int words_per_line);
      return 30 - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Flop-based line storage: data words, tags and valid bits with one combinational
// read port, one word write port and a bulk valid clear.
module icache_line_store
   import riscv_pkg::*;
#(
   parameter int LINES          = ICACHE_LINES,
   parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [icache_idx_w(LINES)-1:0]                     rd_idx_i,
   input  logic [icache_off_w(WORDS_PER_LINE)-1:0]            rd_off_i,
   output logic [icache_tag_w(LINES, WORDS_PER_LINE)-1:0]     rd_tag_o,
   output logic                                               rd_valid_o,
   output logic [31:0]                                        rd_data_o,
   input  logic                                               wr_en_i,
   input  logic [icache_idx_w(LINES)-1:0]                     wr_idx_i,
   input  logic [icache_off_w(WORDS_PER_LINE)-1:0]            wr_off_i,
   input  logic [31:0]                                        wr_data_i,
   input  logic                                               tag_we_i,
   input  logic [icache_tag_w(LINES, WORDS_PER_LINE)-1:0]     wr_tag_i,
   input  logic                                               valid_set_i,
   input  logic                                               clear_all_i
);

   localparam int TB = icache_tag_w(LINES, WORDS_PER_LINE);

   logic [31:0]     data_q [LINES][WORDS_PER_LINE];
   logic [TB-1:0]   tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      end
      if (tag_we_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
      end
   end

   // A bulk clear wins over a same-cycle line fill.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (clear_all_i) begin
         valid_q <= '0;
      end else if (valid_set_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, burst line refill on
// a miss, and whole-cache invalidate for fence.i.
module icache
   import riscv_pkg::*;
#(
   parameter int LINES          = ICACHE_LINES,
   parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_from_fetch,
   input  logic [31:0] pc_from_fetch,
   input  logic        invalidate,
   output logic [31:0] instr_to_fetch,
   output logic        instr_valid_to_fetch,
   output logic        stall_to_fetch,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_valid
);

   localparam int OB = icache_off_w(WORDS_PER_LINE);
   localparam int IB = icache_idx_w(LINES);
   localparam int TB = icache_tag_w(LINES, WORDS_PER_LINE);

   icache_state_t state_q;
   logic [OB-1:0] beat_q;
   logic          drop_q;
   logic          mem_req_q;
   logic [29:0]   mem_addr_q;
   logic [31:0]   instr_q;
   logic          instr_valid_q;

   logic [OB-1:0] pc_off;
   logic [IB-1:0] pc_idx, ref_idx;
   logic [TB-1:0] pc_tag, ref_tag, rd_tag;
   logic          rd_valid, hit, wr_en, last_beat, valid_set;
   logic [31:0]   rd_data;
   logic          unused_pc;

   assign pc_off    = pc_from_fetch[2+:OB];
   assign pc_idx    = pc_from_fetch[2+OB+:IB];
   assign pc_tag    = pc_from_fetch[31:2+OB+IB];
   assign unused_pc = ^pc_from_fetch[1:0];

   // The line being refilled is identified by the latched line address.
   assign ref_idx   = mem_addr_q[OB+:IB];
   assign ref_tag   = mem_addr_q[29:OB+IB];

   assign hit       = rd_valid && (rd_tag == pc_tag) && !invalidate;
   assign wr_en     = (state_q == REFILL_DATA) && mem_rdata_valid;
   assign last_beat = wr_en && (beat_q == OB'(WORDS_PER_LINE - 1));
   assign valid_set = last_beat && !drop_q && !invalidate;

   icache_line_store #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_store (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (pc_idx),
      .rd_off_i    (pc_off),
      .rd_tag_o    (rd_tag),
      .rd_valid_o  (rd_valid),
      .rd_data_o   (rd_data),
      .wr_en_i     (wr_en),
      .wr_idx_i    (ref_idx),
      .wr_off_i    (beat_q),
      .wr_data_i   (mem_rdata),
      .tag_we_i    (last_beat),
      .wr_tag_i    (ref_tag),
      .valid_set_i (valid_set),
      .clear_all_i (invalidate)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         beat_q        <= '0;
         drop_q        <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         instr_valid_q <= 1'b0;
         unique case (state_q)
            RUN: begin
               if (req_valid_from_fetch) begin
                  if (hit) begin
                     instr_q       <= rd_data;
                     instr_valid_q <= 1'b1;
                  end else begin
                     state_q    <= REFILL_REQ;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {pc_from_fetch[31:2+OB], {OB{1'b0}}};
                     drop_q     <= 1'b0;
                  end
               end
            end
            REFILL_REQ: begin
               if (invalidate) drop_q <= 1'b1;
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  beat_q    <= '0;
                  state_q   <= REFILL_DATA;
               end
            end
            REFILL_DATA: begin
               if (invalidate) drop_q <= 1'b1;
               if (mem_rdata_valid) begin
                  beat_q <= beat_q + OB'(1);
                  if (last_beat) begin
                     drop_q  <= 1'b0;
                     state_q <= RUN;
                  end
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign stall_to_fetch       = rst && ((state_q != RUN) ||
                                         (req_valid_from_fetch && !hit));
   assign instr_to_fetch       = instr_q;
   assign instr_valid_to_fetch = instr_valid_q;
   assign mem_req              = mem_req_q;
   assign mem_addr             = mem_addr_q;

endmodule
